// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, Funct3 codes and access-decode helpers
// for the load/store interface.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal Funct3 for the direction, and naturally aligned for its size.
    function automatic logic access_ok(input logic store, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (!store && ((f3 == F3_BU) || (f3 == F3_HU)));
        return legal && !(f3[1:0] == 2'b01 && a[0]) && !(f3[1:0] == 2'b10 && a != 2'b00);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        return f3[1] ? 4'b1111 : (f3[0] ? 4'b0011 : 4'b0001) << a;
    endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext: selects the addressed byte/halfword of a read word and
// sign- or zero-extends it according to Funct3.
module load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = 8'(rdata >> {addr, 3'b000});
    assign h = addr[1] ? rdata[31:16] : rdata[15:0];

    assign data = (funct3 == F3_B)  ? {{24{b[7]}}, b}  :
                  (funct3 == F3_BU) ? {24'b0, b}       :
                  (funct3 == F3_H)  ? {{16{h[15]}}, h} :
                  (funct3 == F3_HU) ? {16'b0, h}       : rdata;

endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: stalls the core while a load/store runs over a registered
// req/ack memory bus, with lane steering, extension and timeout abort.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_t              state_q, state_d;
    logic [TO_WIDTH-1:0] cnt_q, cnt_d;
    logic                req_q, req_d, we_q, we_d, bus_err_q, bus_err_d;
    logic [31:0]         addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d;
    logic [3:0]          be_q, be_d;
    logic [1:0]          lo_q, lo_d;
    logic [2:0]          f3_q, f3_d;
    logic                access, ok;
    logic [31:0]         ext;

    // Low address bits and Funct3 are kept apart because mem_addr is word aligned.
    load_ext u_load_ext (
        .rdata  (mem_rdata),
        .addr   (lo_q),
        .funct3 (f3_q),
        .data   (ext)
    );

    always_comb begin
        access    = MemRead | MemWrite;
        ok        = access_ok(MemWrite, Funct3, ALUResult[1:0]);
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        lo_d      = lo_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && ok) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = {ALUResult[31:2], 2'b00};
                    be_d    = byte_en(Funct3, ALUResult[1:0]);
                    wdata_d = Funct3[1] ? WriteData :
                              Funct3[0] ? {2{WriteData[15:0]}} : {4{WriteData[7:0]}};
                    lo_d    = ALUResult[1:0];
                    f3_d    = Funct3;
                    cnt_d   = '0;
                end else if (access) begin
                    rd_d = '0;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rd_d    = we_q ? rd_q : ext;
                end else if (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = DONE;
                    req_d     = 1'b0;
                    rd_d      = '0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            lo_q      <= lo_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign Stall       = (state_q == REQ) || (state_q == IDLE && access && ok);
    assign MisalignErr = (state_q == IDLE) && access && !ok;
    assign ReadData    = MisalignErr ? 32'h0 : rd_q;
    assign BusErr      = bus_err_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store interface stage sitting directly downstream of the single-cycle datapath. It consumes ALUResult as the address, WriteData as store data, and the control strobes, then returns ReadData to the result mux. Towards memory it drives a registered request/acknowledge bus with variable latency. It stalls the core, via Stall gating the PC and register-file write enables, until each load or store completes. It handles byte/halfword/word lanes, sign/zero extension, misalignment and bus timeout.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ without mem_ack before the access is aborted (1..65535)
TO_WIDTH, 16, width of the timeout counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
MemRead  in  1  load instruction in execute
MemWrite  in  1  store instruction in execute
Funct3  in  3  Instr[14:12], access size/sign
ALUResult  in  32  byte address
WriteData  in  32  store data (rs2)
ReadData  out  32  extended load data to the result mux
Stall  out  1  hold PC/regfile while high
MisalignErr  out  1  one-cycle pulse: misaligned or illegal Funct3
BusErr  out  1  one-cycle pulse: timeout abort
mem_req  out  1  request valid, registered
mem_we  out  1  1 = write
mem_addr  out  32  word address, {ALUResult[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid with mem_ack
mem_ack  in  1  single-cycle completion

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, ReadData=0, MisalignErr=0, BusErr=0, timeout counter=0. Stall follows its combinational rule below, so it is 0 unless a legal access is pending.
- FSM states: IDLE, REQ, DONE.
- IDLE, access requested (MemRead|MemWrite):
  - Legal and aligned: Stall=1 combinationally. Next edge: register mem_addr/mem_we/mem_be/mem_wdata, set mem_req=1, go REQ.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal Funct3 (loads other than 000,001,010,100,101; stores other than 000,001,010): no bus access, Stall=0, MisalignErr=1 for that cycle, ReadData=0, stay IDLE.
- MemRead and MemWrite both high: treated as a store.
- REQ: mem_req held 1 and all request fields held stable. Counter increments each cycle.
  - mem_ack=1: capture the extended load result into ReadData, drop mem_req on the next edge, go DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: drop mem_req, ReadData=0, BusErr=1 during DONE, go DONE.
- DONE: exactly one cycle, Stall=0 so the core commits; ReadData stable; return to IDLE and clear the counter.
- Minimum latency with ack in the first REQ cycle: 3 cycles per memory instruction (IDLE, REQ, DONE). Non-memory instructions take 0 stall cycles.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{WriteData[7:0]}}
  - SH: be=0011<<addr[1:0], wdata={2{WriteData[15:0]}}
  - SW: be=1111, wdata=WriteData
- Loads: mem_be is set as for stores of the same size. The byte/half at addr[1:0] is sign-extended (LB/LH) or zero-extended (LBU/LHU); LW passes through unchanged.
- mem_ack outside REQ is ignored. An ack arriving in the same cycle as the timeout wins over the timeout (normal completion, no BusErr).
- Reset mid-REQ: mem_req drops immediately; any late ack is then ignored in IDLE.
- Write completion: ReadData is not updated on a write completion.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE,REQ,DONE}
  - Funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - function for misalignment/legality check
- Sub-module load_ext (combinational): takes mem_rdata, addr[1:0] and Funct3, and produces the 32-bit extended load value. It is used at the REQ capture point.

Test Plan:
- LW addr 0x100, memory acks 1st REQ cycle with 0xDEADBEEF -> Stall high 2 cycles, ReadData=0xDEADBEEF in DONE, mem_be=1111, mem_addr=0x100.
- LB addr 0x103, rdata 0x80FF_0000 -> ReadData=0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, WriteData 0x123456AB -> mem_be=0010, mem_wdata=0xABABABAB, mem_we=1, ReadData unchanged.
- LW addr 0x102 -> no mem_req, MisalignErr pulse 1 cycle, Stall=0, ReadData=0. Funct3=011 load -> same response.
- TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles then drops, BusErr pulse in DONE, ReadData=0. Ack on cycle 4 -> normal completion, no BusErr.
- reset asserted during REQ with ack 1 cycle after release -> mem_req=0 immediately, state IDLE, ack ignored, ReadData=0.
